// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: arbiter FSM encoding and default BRAM geometry.
package cpu_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// CPU, video and BRAM port bundle; slave is the arbiter's view, master the requesters/BRAM side.
interface bram_port_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bram_port_arbiter_starve_counter.sv
// Saturating count of CPU arbitration losses; clear has priority over increment.
module starve_counter #(
  parameter int LIMIT = 4  // must be >= 1
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int              CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && cnt != MAX)
      cnt <= cnt + CNT_W'(1);
  end

  assign sat = (cnt >= MAX);
endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a single BRAM port: video wins ties unless the CPU has starved.
// Grant -> ISSUE (1 cycle) -> RESP (1 cycle, ack + rdata pass-through); re-arbitrates in RESP.
module bram_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset,
  bram_port_arbiter_if.slave bus
);
  arb_state_t        state, state_nxt;
  logic              owner_cpu;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic any_req, pick_cpu, latch, starve_sat, starve_inc, starve_clr;
  logic issue, resp;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat)
  );

  always_comb begin
    state_nxt  = state;
    any_req    = bus.cpu_req | bus.vid_req;
    pick_cpu   = bus.cpu_req & (~bus.vid_req | starve_sat);
    latch      = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    case (state)
      // RESP arbitrates like IDLE so back-to-back accesses need no bubble
      IDLE, RESP: begin
        latch      = any_req;
        state_nxt  = any_req ? ISSUE : IDLE;
        starve_inc = any_req & bus.cpu_req & ~pick_cpu;
        starve_clr = any_req & pick_cpu;
      end
      ISSUE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner_cpu <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        owner_cpu <= pick_cpu;
        lat_we    <= pick_cpu & bus.cpu_we;
        lat_addr  <= pick_cpu ? bus.cpu_addr : bus.vid_addr;
        lat_wdata <= pick_cpu ? bus.cpu_wdata : '0;
      end
    end
  end

  assign issue = (state == ISSUE);
  assign resp  = (state == RESP);

  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & lat_we;
  assign bus.mem_addr  = issue ? lat_addr : '0;
  assign bus.mem_wdata = issue ? lat_wdata : '0;

  assign bus.cpu_ack   = resp & owner_cpu;
  assign bus.vid_ack   = resp & ~owner_cpu;
  assign bus.cpu_rdata = bus.cpu_ack ? bus.mem_rdata : '0;
  assign bus.vid_rdata = bus.vid_ack ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a 1-cycle-latency BRAM model.
module tb_bram_port_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bram_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  bram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] mem [0:65535];
  logic [15:0] bram_q;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hBEEF;
    bram_q = 16'h0000;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bram_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = bram_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_en"},    32'(bus.mem_en),    32'h0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'h0);
    check({tag, "_cpu_ack"},   32'(bus.cpu_ack),   32'h0);
    check({tag, "_vid_ack"},   32'(bus.vid_ack),   32'h0);
    check({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'h0);
    check({tag, "_vid_rdata"}, 32'(bus.vid_rdata), 32'h0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'h0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'h0);
  endtask

  initial begin
    logic exp_c;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0;
    bus.cpu_wdata = 16'h0;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = 16'h0;

    #2;
    check_quiet("reset");

    // CPU load of 0x0010; first arbitration on the first edge after release
    step();
    reset        = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0010;
    step();
    check("ld_issue_en",   32'(bus.mem_en),   32'h1);
    check("ld_issue_we",   32'(bus.mem_we),   32'h0);
    check("ld_issue_addr", 32'(bus.mem_addr), 32'h0010);
    check("ld_issue_ack",  32'(bus.cpu_ack),  32'h0);
    step();
    check("ld_ack",       32'(bus.cpu_ack),   32'h1);
    check("ld_rdata",     32'(bus.cpu_rdata), 32'hBEEF);
    check("ld_vid_ack",   32'(bus.vid_ack),   32'h0);
    check("ld_resp_en",   32'(bus.mem_en),    32'h0);
    bus.cpu_req = 1'b0;
    step();
    check_quiet("ld_idle");

    // CPU store 0x0020 <- 0x1234, then video reads it back
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h0020;
    bus.cpu_wdata = 16'h1234;
    step();
    check("st_issue_en",    32'(bus.mem_en),    32'h1);
    check("st_issue_we",    32'(bus.mem_we),    32'h1);
    check("st_issue_addr",  32'(bus.mem_addr),  32'h0020);
    check("st_issue_wdata", 32'(bus.mem_wdata), 32'h1234);
    bus.cpu_wdata = 16'hDEAD;  // must be ignored after grant
    step();
    check("st_ack",     32'(bus.cpu_ack), 32'h1);
    check("st_resp_we", 32'(bus.mem_we),  32'h0);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    step();
    check("st_idle_ack", 32'(bus.cpu_ack), 32'h0);
    bus.vid_req  = 1'b1;
    bus.vid_addr = 16'h0020;
    step();
    check("vr_issue_en",   32'(bus.mem_en),   32'h1);
    check("vr_issue_we",   32'(bus.mem_we),   32'h0);
    check("vr_issue_addr", 32'(bus.mem_addr), 32'h0020);
    step();
    check("vr_ack",       32'(bus.vid_ack),   32'h1);
    check("vr_rdata",     32'(bus.vid_rdata), 32'h1234);
    check("vr_cpu_ack",   32'(bus.cpu_ack),   32'h0);
    check("vr_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
    bus.vid_req = 1'b0;
    step();
    check_quiet("vr_idle");

    // Both held: grant order V,V,V,V,C repeated twice
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0010;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      exp_c = (i % 5 == 4);
      step();
      check($sformatf("arb%0d_issue_en", i),   32'(bus.mem_en),   32'h1);
      check($sformatf("arb%0d_issue_addr", i), 32'(bus.mem_addr), exp_c ? 32'h0010 : 32'h0020);
      step();
      check($sformatf("arb%0d_cpu_ack", i),   32'(bus.cpu_ack),   32'(exp_c));
      check($sformatf("arb%0d_vid_ack", i),   32'(bus.vid_ack),   32'(!exp_c));
      check($sformatf("arb%0d_cpu_rdata", i), 32'(bus.cpu_rdata), exp_c ? 32'hBEEF : 32'h0);
      check($sformatf("arb%0d_vid_rdata", i), 32'(bus.vid_rdata), exp_c ? 32'h0 : 32'h1234);
    end
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    step();
    check_quiet("arb_idle");

    // Video alone held: one access every two cycles, no bubble
    bus.vid_req  = 1'b1;
    bus.vid_addr = 16'h0010;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("vs%0d_mem_en", i),  32'(bus.mem_en),  32'(i % 2 == 0));
      check($sformatf("vs%0d_vid_ack", i), 32'(bus.vid_ack), 32'(i % 2 == 1));
      check($sformatf("vs%0d_cpu_ack", i), 32'(bus.cpu_ack), 32'h0);
    end
    check("vs_rdata", 32'(bus.vid_rdata), 32'hBEEF);
    bus.vid_req = 1'b0;
    step();
    check_quiet("vs_idle");

    // Reset pulsed during ISSUE of a CPU load
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0010;
    step();
    check("rst_issue_en", 32'(bus.mem_en), 32'h1);
    reset = 1'b1;
    #1;
    check_quiet("rst_async");
    bus.cpu_req = 1'b0;
    step();
    check_quiet("rst_held");
    reset = 1'b0;
    step();
    check_quiet("rst_release");
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0020;
    step();
    check("post_issue_en",   32'(bus.mem_en),   32'h1);
    check("post_issue_addr", 32'(bus.mem_addr), 32'h0020);
    step();
    check("post_ack",   32'(bus.cpu_ack),   32'h1);
    check("post_rdata", 32'(bus.cpu_rdata), 32'h1234);
    bus.cpu_req = 1'b0;
    step();
    check_quiet("post_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
